// File: rtl/temp_sensor_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// temp_sensor_ctrl_pkg
// Shared definitions for the thermostat temperature-sensor SPI reader and the
// downstream SPI-to-temperature conversion block.
//   - FSM state encodings (3-bit)
//   - SPI word width and number of SCLK edges per frame
//   - Field positions inside the received 16-bit word:
//       bit 15     : lead bit, must be 0 for a valid frame
//       bits 14:5  : temperature
//       bits 4:0   : padding
// -----------------------------------------------------------------------------
package temp_sensor_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CS_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT    = 3'd2;
    localparam logic [2:0] ST_CS_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_CS_SETUP = ST_CS_SETUP,
        S_SHIFT    = ST_SHIFT,
        S_CS_HOLD  = ST_CS_HOLD,
        S_DONE     = ST_DONE
    } state_t;

    localparam int SPI_WORD_W = 16;
    localparam int SPI_EDGES  = 32;

    localparam int WORD_LEAD_BIT = 15;
    localparam int WORD_TEMP_MSB = 14;
    localparam int WORD_TEMP_LSB = 5;
    localparam int WORD_PAD_MSB  = 4;
    localparam int WORD_PAD_LSB  = 0;

    // A frame is good only when the lead bit reads back as 0.
    function automatic logic word_is_valid(input logic [SPI_WORD_W-1:0] w);
        return ~w[WORD_LEAD_BIT];
    endfunction

    function automatic logic [WORD_TEMP_MSB-WORD_TEMP_LSB:0] word_temp(
        input logic [SPI_WORD_W-1:0] w);
        return w[WORD_TEMP_MSB:WORD_TEMP_LSB];
    endfunction

    function automatic logic [WORD_PAD_MSB-WORD_PAD_LSB:0] word_pad(
        input logic [SPI_WORD_W-1:0] w);
        return w[WORD_PAD_MSB:WORD_PAD_LSB];
    endfunction

endpackage

// File: rtl/temp_sensor_ctrl_tick.sv
// -----------------------------------------------------------------------------
// spi_tick_gen
// SCLK half-period divider. Counts 0..CLK_DIV-1 and flags the terminal count.
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset
//   i_clear  holds the counter at 0 (used while the controller is idle)
//   o_tick   high in the cycle where the count equals CLK_DIV-1
// -----------------------------------------------------------------------------
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/temp_sensor_ctrl.sv
// -----------------------------------------------------------------------------
// temp_sensor_ctrl
// Periodic 16-bit SPI reader (mode 0, MSB first, read-only) for the thermostat
// temperature sensor. Owns CS, SCLK and sample timing and presents the last
// good word to the conversion block.
// Ports:
//   i_clk         system clock
//   i_rst_n       synchronous active-low reset
//   i_enable      1 = periodic sampling every SAMPLE_PERIOD clocks
//   i_start_now   one-cycle pulse requesting an immediate read
//   i_spi_miso    sensor data out (already synchronised upstream)
//   o_spi_cs_n    chip select, active low
//   o_spi_clk     SCLK, idles low
//   o_spi_data    last valid received word
//   o_data_valid  one-cycle pulse when o_spi_data updates
//   o_frame_err   one-cycle pulse when a received word has bit 15 set
//   o_busy        high while CS is asserted
// -----------------------------------------------------------------------------
module temp_sensor_ctrl
    import temp_sensor_ctrl_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_start_now,
    input  logic                  i_spi_miso,
    output logic                  o_spi_cs_n,
    output logic                  o_spi_clk,
    output logic [SPI_WORD_W-1:0] o_spi_data,
    output logic                  o_data_valid,
    output logic                  o_frame_err,
    output logic                  o_busy
);

    localparam int PW     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int EDGE_W = $clog2(SPI_EDGES);

    state_t                r_state;
    logic [PW-1:0]         r_period_cnt;
    logic                  r_pending;
    logic [EDGE_W-1:0]     r_edge_cnt;
    logic [SPI_WORD_W-1:0] r_shift;
    logic                  r_cs_n;
    logic                  r_spi_clk;
    logic [SPI_WORD_W-1:0] r_spi_data;
    logic                  r_data_valid;
    logic                  r_frame_err;
    logic                  r_busy;

    logic w_tick;
    logic w_period_tc;
    logic w_req;
    logic w_take;

    // Divider is held cleared in IDLE so CS_SETUP always starts from count 0.
    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (r_state == S_IDLE),
        .o_tick  (w_tick)
    );

    assign w_period_tc = i_enable && (r_period_cnt == PW'(SAMPLE_PERIOD - 1));
    assign w_req       = w_period_tc | i_start_now;
    assign w_take      = (r_state == S_IDLE) && r_pending;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_enable) begin
            r_period_cnt <= '0;
        end else if (w_period_tc) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    // Single pending flag; a new request in the same cycle the flag is
    // consumed re-arms it so nothing is lost.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_req | (r_pending & ~w_take);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cs_n       <= 1'b1;
            r_spi_clk    <= 1'b0;
            r_spi_data   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
            r_edge_cnt   <= '0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cs_n    <= 1'b1;
                    r_spi_clk <= 1'b0;
                    if (r_pending) begin
                        r_state <= S_CS_SETUP;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CS_SETUP: begin
                    if (w_tick) begin
                        r_state    <= S_SHIFT;
                        r_edge_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        // Even count = odd edge number: SCLK rises and MISO is
                        // captured in this same tick cycle.
                        if (!r_edge_cnt[0]) begin
                            r_spi_clk <= 1'b1;
                            r_shift   <= {r_shift[SPI_WORD_W-2:0], i_spi_miso};
                        end else begin
                            r_spi_clk <= 1'b0;
                        end
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                        if (r_edge_cnt == EDGE_W'(SPI_EDGES - 1)) begin
                            r_state <= S_CS_HOLD;
                        end
                    end
                end
                S_CS_HOLD: begin
                    // Outputs are registered here so they are visible during
                    // the single DONE cycle.
                    if (w_tick) begin
                        r_state <= S_DONE;
                        r_cs_n  <= 1'b1;
                        r_busy  <= 1'b0;
                        if (word_is_valid(r_shift)) begin
                            r_spi_data   <= r_shift;
                            r_data_valid <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_spi_cs_n   = r_cs_n;
    assign o_spi_clk    = r_spi_clk;
    assign o_spi_data   = r_spi_data;
    assign o_data_valid = r_data_valid;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = r_busy;

endmodule

// File: doc/temp_sensor_ctrl.md
Name: temp_sensor_ctrl

Overview:
- Sequences periodic 16-bit SPI reads from the thermostat temperature sensor (SPI mode 0, MSB first, read-only).
- Presents the last good word on o_spi_data. That bus feeds the SPI-to-temperature conversion block directly; word format is {1'b0, temp[9:0], 5 padding bits}.
- Sits between the sensor pins and the temperature datapath. Owns CS, SCLK and sample timing.

Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period (min 1).
- SAMPLE_PERIOD, 100000, system clocks between periodic read requests (min 1).

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_enable  input  1  1 = periodic sampling runs.
- i_start_now  input  1  one-cycle pulse; requests an immediate read.
- i_spi_miso  input  1  sensor data out.
- o_spi_cs_n  output  1  sensor chip select, active low.
- o_spi_clk  output  1  SCLK, idles low.
- o_spi_data  output  16  last valid received word.
- o_data_valid  output  1  one-cycle pulse when o_spi_data updates.
- o_frame_err  output  1  one-cycle pulse when the received word has bit15 = 1.
- o_busy  output  1  high from CS assertion through the CS-deassert cycle.

Behaviour:
- Clock/reset: single clock i_clk. Reset is synchronous, active low (i_rst_n).
- Reset values:
  - o_spi_cs_n = 1, o_spi_clk = 0, o_spi_data = 16'h0000.
  - o_data_valid = 0, o_frame_err = 0, o_busy = 0.
  - Period counter = 0, pending request cleared, state = IDLE.
- Reset mid-transaction: aborts on the next edge, with the reset values above and no valid/err pulse.
- Tick: divider counts 0..CLK_DIV-1 and only runs outside IDLE. A tick is the cycle where count = CLK_DIV-1. The divider clears on entry to CS_SETUP.
- Period counter:
  - Runs while i_enable = 1 and counts 0..SAMPLE_PERIOD-1. At terminal count it sets a pending request and wraps to 0.
  - i_enable = 0 clears the counter and holds it.
  - i_start_now also sets pending.
  - Pending is a single flag: multiple requests while busy collapse into one.
- States:
  - IDLE: CS_n = 1, SCLK = 0. If pending, go to CS_SETUP next cycle, clear pending, assert CS_n = 0 and o_busy = 1.
  - CS_SETUP: wait one tick, then go to SHIFT.
  - SHIFT: 32 ticks.
    - Odd ticks (1, 3, ...): SCLK rises and i_spi_miso shifts into the LSB of the shift register.
    - Even ticks: SCLK falls.
    - After tick 32, SCLK = 0; go to CS_HOLD.
  - CS_HOLD: wait one tick, then go to DONE.
  - DONE (one cycle):
    - CS_n = 1, o_busy = 0.
    - If shift[15] = 0: o_spi_data <= shift and o_data_valid pulses.
    - Else: o_frame_err pulses and o_spi_data holds.
    - Next state IDLE.
- Timing:
  - CS_n is low for exactly 34*CLK_DIV cycles.
  - Pulse appears 34*CLK_DIV cycles after the cycle in which CS_n fell.
- Request handling:
  - A request arriving during a transaction is serviced immediately after DONE. No back-to-back IDLE gap beyond 1 cycle.
  - i_enable falling mid-transaction: the current transaction completes. Any pending request set by i_start_now is still serviced.
- Simultaneous events: a period terminal count and i_start_now in the same cycle produce one transaction.
- Sampling: i_spi_miso is sampled on the tick cycle itself. The external pin is synchronised by the top level, not here.

Decomposition:
- Shared package holds:
  - State encodings IDLE/CS_SETUP/SHIFT/CS_HOLD/DONE (3-bit localparams).
  - SPI_WORD_W = 16 and SPI_EDGES = 32.
  - The word field positions (sign/lead bit 15, temp bits 14:5, pad bits 4:0), shared with the conversion block.
- One natural sub-module, spi_tick_gen: parameterised CLK_DIV counter with clear input and tick output.

Test Plan:
- Sensor model returns 16'h0A80 (21C); CLK_DIV = 2, i_start_now pulse.
  - CS_n low for 68 cycles.
  - 16 SCLK rising edges.
  - o_data_valid pulses once, and o_spi_data = 16'h0A80 in that cycle.
- i_enable = 1, SAMPLE_PERIOD = 200, CLK_DIV = 1, model word 16'h0A60.
  - CS_n falls at cycles 201, 401, 601 after enable (1 cycle after each terminal count).
  - Each read yields 16'h0A60.
- Model drives MISO stuck high (16'hFFFF).
  - o_frame_err pulses and o_data_valid stays 0.
  - o_spi_data keeps its previous value 16'h0A80.
- i_start_now pulsed twice during an active transaction, plus a period terminal count in the same window: exactly one extra transaction follows, starting 1 cycle after DONE.
- i_rst_n low at SHIFT tick 10:
  - Next cycle CS_n = 1, SCLK = 0, o_spi_data = 0, no pulses.
  - After release with i_enable = 0 and no i_start_now, no activity occurs.
- i_enable dropped mid-transaction: the transaction completes with valid 16'h0A80, then no further CS activity for 2*SAMPLE_PERIOD cycles.
